// File: rtl/traffic_intersection_ctrl.sv
// Round-robin N_DIR-approach intersection controller with pedestrian-extended greens.
// Define FLASH_MODE_EN to add the 'flash' input and a flashing-yellow state.
module traffic_intersection_ctrl #(
  parameter int N_DIR           = 4,
  parameter int GREEN_TICKS     = 8,
  parameter int YELLOW_TICKS    = 3,
  parameter int ALLRED_TICKS    = 2,
  parameter int PED_EXTRA_TICKS = 4,
  parameter int CNT_W           = 8,
  parameter int FLASH_HALF      = 5,
  localparam int DW = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
`ifdef FLASH_MODE_EN
  input  logic             flash,
`endif
  input  logic [N_DIR-1:0] ped_req,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] walk,
  output logic [DW-1:0]    cur_dir
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
`ifdef FLASH_MODE_EN
    , S_FLASH = 2'd3
`endif
  } state_t;

  localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] GP_LOAD = CNT_W'(GREEN_TICKS + PED_EXTRA_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [N_DIR-1:0] ONE     = N_DIR'(1);

  // Reject parameter sets the timer or state machine cannot honour.
  if (N_DIR < 2 || GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 ||
      PED_EXTRA_TICKS < 0 || FLASH_HALF < 1 ||
      (GREEN_TICKS + PED_EXTRA_TICKS - 1) >= (2 ** CNT_W)) begin : g_bad_params
    $error("traffic_intersection_ctrl: illegal parameter combination");
  end

`ifdef FLASH_MODE_EN
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLASH_HALF - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [N_DIR-1:0] ped_pend;
  logic [DW-1:0]    nxt_dir;
  logic [N_DIR-1:0] nxt_mask;
  logic             served;

  // A request arriving on the very edge that opens the green still counts as served.
  always_comb begin
    nxt_dir  = (cur_dir == DW'(N_DIR - 1)) ? '0 : cur_dir + 1'b1;
    nxt_mask = ONE << nxt_dir;
    served   = |(nxt_mask & (ped_pend | ped_req));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_ALLRED;
      cur_dir  <= DW'(N_DIR - 1);
      timer    <= AR_LOAD;
      red      <= '1;
      yellow   <= '0;
      green    <= '0;
      walk     <= '0;
      ped_pend <= '0;
    end else begin
      ped_pend <= ped_pend | ped_req;
`ifdef FLASH_MODE_EN
      if (flash) begin
        if (state != S_FLASH) begin
          state  <= S_FLASH;
          timer  <= FL_LOAD;
          red    <= '0;
          green  <= '0;
          walk   <= '0;
          yellow <= '1;
        end else if (enable) begin
          if (timer == '0) begin
            timer  <= FL_LOAD;
            yellow <= ~yellow;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      end else if (state == S_FLASH) begin
        state  <= S_ALLRED;
        timer  <= AR_LOAD;
        red    <= '1;
        yellow <= '0;
      end else
`endif
      if (enable) begin
        if (timer != '0) begin
          timer <= timer - 1'b1;
        end else begin
          case (state)
            S_ALLRED: begin
              state    <= S_GREEN;
              cur_dir  <= nxt_dir;
              green    <= nxt_mask;
              red      <= ~nxt_mask;
              walk     <= served ? nxt_mask : '0;
              timer    <= served ? GP_LOAD : G_LOAD;
              ped_pend <= (ped_pend | ped_req) & ~nxt_mask;
            end
            S_GREEN: begin
              state  <= S_YELLOW;
              yellow <= ONE << cur_dir;
              green  <= '0;
              walk   <= '0;
              timer  <= Y_LOAD;
            end
            S_YELLOW: begin
              state  <= S_ALLRED;
              yellow <= '0;
              red    <= '1;
              timer  <= AR_LOAD;
            end
            default: begin
              state  <= S_ALLRED;
              red    <= '1;
              yellow <= '0;
              green  <= '0;
              walk   <= '0;
              timer  <= AR_LOAD;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a cycle-count reference model.
module tb_traffic_intersection_ctrl;

  localparam int N = 4, G = 8, Y = 3, AR = 2, PX = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
`ifdef FLASH_MODE_EN
  logic       flash;
`endif
  logic [3:0] ped_req;
  logic [3:0] red, yellow, green, walk;
  logic [1:0] cur_dir;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
`ifdef FLASH_MODE_EN
    .flash  (flash),
`endif
    .ped_req(ped_req),
    .red    (red),
    .yellow (yellow),
    .green  (green),
    .walk   (walk),
    .cur_dir(cur_dir)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0=green 1=yellow 2=all-red, mRemain counts cycles left.
  int       mPhase, mRemain, mDir;
  bit       mWalk;
  bit [3:0] mPend;

  task automatic modelReset();
    mPhase = 2; mRemain = AR; mDir = N - 1; mWalk = 0; mPend = '0;
  endtask

  task automatic modelStep(input bit en, input bit [3:0] req);
    bit [3:0] np;
    np = mPend | req;
    if (en) begin
      mRemain--;
      if (mRemain == 0) begin
        if (mPhase == 2) begin
          mDir    = (mDir + 1) % N;
          mWalk   = np[mDir];
          np[mDir] = 1'b0;
          mRemain = mWalk ? G + PX : G;
          mPhase  = 0;
        end else if (mPhase == 0) begin
          mPhase = 1; mRemain = Y; mWalk = 0;
        end else begin
          mPhase = 2; mRemain = AR;
        end
      end
    end
    mPend = np;
  endtask

  function automatic logic [17:0] modelOut();
    logic [3:0] m, r, yl, g, w;
    m  = 4'b0001 << mDir;
    r  = (mPhase == 2) ? 4'hF : ~m;
    yl = (mPhase == 1) ? m : 4'h0;
    g  = (mPhase == 0) ? m : 4'h0;
    w  = (mPhase == 0 && mWalk) ? m : 4'h0;
    return {2'(mDir), w, g, yl, r};
  endfunction

  function automatic logic [17:0] dutOut();
    return {cur_dir, walk, green, yellow, red};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic applyStimulus(input bit en, input bit [3:0] req);
    enable  = en;
    ped_req = req;
    @(posedge clock);
    modelStep(en, req);
    #1;
    ped_req = '0;
    checkOutput("model", 32'(dutOut()), 32'(modelOut()));
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b1; ped_req = '0;
    @(posedge clock); #1;
    modelReset();
    checkOutput("reset_out", 32'(dutOut()), {14'b0, 2'd3, 4'h0, 4'h0, 4'h0, 4'hF});
    reset = 1'b0;
  endtask

  task automatic waitGreen(input logic [3:0] target);
    int n;
    n = 0;
    while (green !== target && n < 200) begin
      applyStimulus(1'b1, '0);
      n++;
    end
    if (green !== target) checkOutput("wait_green_timeout", 32'(green), 32'(target));
  endtask

  typedef struct {
    int         rep;
    bit         en;
    logic [3:0] req, r, yl, g, w;
    logic [1:0] dir;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt;
    bit allWalk, anyWalk;
    logic [1:0] prevDir;

    reset = 1'b1; enable = 1'b0; ped_req = '0;
`ifdef FLASH_MODE_EN
    flash = 1'b0;
`endif
    vecs.push_back('{1, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd3});
    vecs.push_back('{8, 1'b1, 4'h0, 4'hE, 4'h0, 4'h1, 4'h0, 2'd0});
    vecs.push_back('{3, 1'b1, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{2, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{1, 1'b1, 4'h0, 4'hD, 4'h0, 4'h2, 4'h0, 2'd1});
    vecs.push_back('{3, 1'b0, 4'h8, 4'hD, 4'h0, 4'h2, 4'h0, 2'd1});

    // Directed start-up sequence
    repeat (2) @(posedge clock);
    doReset();
    foreach (vecs[i]) begin
      repeat (vecs[i].rep) begin
        applyStimulus(vecs[i].en, vecs[i].req);
        checkOutput($sformatf("vec%0d", i), 32'(dutOut()),
                    32'({vecs[i].dir, vecs[i].w, vecs[i].g, vecs[i].yl, vecs[i].r}));
      end
    end

    // Full rotation wraps back to approach 0
    doReset();
    waitGreen(4'b0001);
    prevDir = cur_dir;
    repeat (52) begin
      prevDir = cur_dir;
      applyStimulus(1'b1, '0);
    end
    checkOutput("wrap_green", 32'(green), 32'h1);
    checkOutput("wrap_dir", 32'(cur_dir), 32'h0);
    checkOutput("wrap_prev_dir", 32'(prevDir), 32'h3);

    // Pedestrian request served with extended green, then not repeated
    doReset();
    waitGreen(4'b0001);
    applyStimulus(1'b1, 4'b0100);
    waitGreen(4'b0100);
    cnt = 1; allWalk = walk[2];
    while (cnt < 100) begin
      applyStimulus(1'b1, '0);
      if (green !== 4'b0100) break;
      cnt++; allWalk &= walk[2];
    end
    checkOutput("ped_green_len", 32'(cnt), 32'd12);
    checkOutput("ped_walk_held", 32'(allWalk), 32'd1);
    checkOutput("ped_walk_drop", 32'(walk), 32'h0);
    waitGreen(4'b0100);
    cnt = 1; anyWalk = walk[2];
    while (cnt < 100) begin
      applyStimulus(1'b1, '0);
      if (green !== 4'b0100) break;
      cnt++; anyWalk |= walk[2];
    end
    checkOutput("ped_next_len", 32'(cnt), 32'd8);
    checkOutput("ped_next_walk", 32'(anyWalk), 32'd0);

    // Enable freeze during approach 1 yellow
    doReset();
    cnt = 0;
    while (yellow !== 4'b0010 && cnt < 200) begin applyStimulus(1'b1, '0); cnt++; end
    applyStimulus(1'b1, '0);
    cnt = 2;
    repeat (5) begin
      applyStimulus(1'b0, '0);
      checkOutput("freeze_yellow", 32'(yellow), 32'h2);
      cnt++;
    end
    while (cnt < 100) begin
      applyStimulus(1'b1, '0);
      if (yellow !== 4'b0010) break;
      cnt++;
    end
    checkOutput("freeze_len", 32'(cnt), 32'd8);

    // Asynchronous reset in the middle of a green
    waitGreen(4'b1000);
    applyStimulus(1'b1, '0);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_red", 32'(red), 32'hF);
    checkOutput("async_green", 32'(green), 32'h0);
    checkOutput("async_walk", 32'(walk), 32'h0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, '0);
    checkOutput("restart_red", 32'(red), 32'hF);
    applyStimulus(1'b1, '0);
    checkOutput("restart_green", 32'(green), 32'h1);

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
    end

`ifdef FLASH_MODE_EN
    // Flash mode entry, toggle cadence and exit
    doReset();
    waitGreen(4'b0010);
    flash = 1'b1;
    @(posedge clock); #1;
    checkOutput("flash_yellow_on", 32'(yellow), 32'hF);
    checkOutput("flash_red", 32'(red), 32'h0);
    checkOutput("flash_green", 32'(green), 32'h0);
    cnt = 1;
    while (cnt < 20) begin
      @(posedge clock); #1;
      if (yellow !== 4'hF) break;
      cnt++;
    end
    checkOutput("flash_on_len", 32'(cnt), 32'd5);
    checkOutput("flash_yellow_off", 32'(yellow), 32'h0);
    cnt = 1;
    while (cnt < 20) begin
      @(posedge clock); #1;
      if (yellow !== 4'h0) break;
      cnt++;
    end
    checkOutput("flash_off_len", 32'(cnt), 32'd5);
    flash = 1'b0;
    @(posedge clock); #1;
    checkOutput("flash_exit_red1", 32'(red), 32'hF);
    @(posedge clock); #1;
    checkOutput("flash_exit_red2", 32'(red), 32'hF);
    @(posedge clock); #1;
    checkOutput("flash_exit_green", 32'(green), 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Parametrised successor to the single-approach traffic light controller. It sequences N_DIR approaches round-robin through green, yellow and all-red phases using programmable tick counts. It also latches pedestrian requests, extends the green for a served request, and supports a global enable (tick qualifier). It sits at the top of the intersection subsystem and drives the lamp outputs directly.

Parameters:
N_DIR, 4, number of approaches (>=2)
GREEN_TICKS, 8, green duration in enabled cycles (>=1)
YELLOW_TICKS, 3, yellow duration (>=1)
ALLRED_TICKS, 2, all-red clearance duration (>=1)
PED_EXTRA_TICKS, 4, extra green added when a pedestrian request is served (>=0)
CNT_W, 8, timer width; must hold GREEN_TICKS+PED_EXTRA_TICKS-1
FLASH_HALF, 5, flash half-period in enabled cycles; used only with FLASH_MODE_EN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  tick qualifier; 0 freezes timer and state
ped_req  in  N_DIR  pedestrian request pulses, one per approach
red  out  N_DIR  red lamp per approach
yellow  out  N_DIR  yellow lamp per approach
green  out  N_DIR  green lamp per approach
walk  out  N_DIR  walk signal per approach
cur_dir  out  $clog2(N_DIR)  approach currently owning green/yellow

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are registered Moore outputs.
- States: S_GREEN, S_YELLOW, S_ALLRED (plus S_FLASH under the macro).
- Reset values (immediate on reset assert):
  - state=S_ALLRED, cur_dir=N_DIR-1, timer=ALLRED_TICKS-1
  - red=all 1, yellow=0, green=0, walk=0, ped_pend=0
- Timer:
  - Loaded with (duration-1) on entering a state.
  - Decrements on each cycle with enable=1.
  - The state transitions on a cycle where enable=1 and timer==0.
  - enable=0 holds state, timer and outputs unchanged.
- Transitions:
  - S_ALLRED -> S_GREEN; cur_dir advances to cur_dir+1, wrapping N_DIR-1 -> 0.
  - S_GREEN -> S_YELLOW.
  - S_YELLOW -> S_ALLRED.
- Lamp outputs:
  - S_GREEN: green[cur_dir]=1; red=1 on all other approaches.
  - S_YELLOW: yellow[cur_dir]=1; red=1 on all other approaches.
  - S_ALLRED: red=all 1.
  - Exactly one lamp is on per approach in every non-flash state.
- Pedestrian handling:
  - ped_req[i]=1 in any cycle sets ped_pend[i]; enable does not affect capture.
  - On entry to S_GREEN for approach i, served = ped_pend[i] | ped_req[i].
    - served=1: ped_pend[i] cleared; walk[i]=1 for the whole green; green timer loaded with GREEN_TICKS+PED_EXTRA_TICKS-1.
    - served=0: green timer loaded with GREEN_TICKS-1; walk[i] stays 0.
  - walk[i] drops on the S_GREEN -> S_YELLOW transition.
  - A request for i arriving during i's own green/yellow/all-red after entry stays pending and is served at i's next green.
  - Multiple requests to different approaches are latched independently.
- Rotation length without pedestrian requests: N_DIR*(GREEN_TICKS+YELLOW_TICKS+ALLRED_TICKS) enabled cycles.
- Reset mid-operation: outputs return to the all-red reset values asynchronously. The first green after reset release goes to approach 0, after ALLRED_TICKS enabled cycles.

Optional Feature:
Macro FLASH_MODE_EN.
- Defined:
  - Adds input port flash (1 bit, placed after enable).
  - flash=1 sampled on a clock edge enters S_FLASH from any state on that edge.
  - In S_FLASH: red=0, green=0, walk=0; yellow=all 1 / all 0, toggling every FLASH_HALF enabled cycles, starting at all 1.
  - ped_pend still captures requests during S_FLASH.
  - flash=0 leaves S_FLASH to S_ALLRED with timer=ALLRED_TICKS-1 and cur_dir unchanged; the next green is cur_dir+1.
- Not defined: no flash port, no S_FLASH state, and FLASH_HALF is ignored.

Test Plan:
- Reset/sequence: defaults, enable=1, release reset.
  - red=4'b1111 for 2 cycles, then green=4'b0001 for 8, yellow=4'b0001 for 3, red=4'b1111 for 2, then green=4'b0010.
  - cur_dir reads 0 during approach 0's green.
- Wrap: run 52 cycles past the first green -> green=4'b0001 again, with cur_dir wrapping 3 -> 0.
- Pedestrian: pulse ped_req[2] for 1 cycle during approach 0's green.
  - Approach 2 green and walk[2]=1 last 12 cycles; ped_pend[2] cleared.
  - Approach 2's following green lasts 8 cycles with walk[2]=0.
- Freeze: drop enable for 5 cycles on the 2nd yellow cycle of approach 1 -> yellow=4'b0010 held for 8 cycles total.
- Async reset: assert reset mid-green without a clock edge -> red=4'b1111, green=0, walk=0 immediately; sequence restarts as in the first scenario.
- Flash (FLASH_MODE_EN): assert flash during approach 1 green.
  - Next edge: yellow=4'b1111 for 5 cycles, then 4'b0000 for 5 cycles, and so on.
  - Deassert flash: all-red for 2 cycles, then green=4'b0100.
